// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared constants and types for the CAM lookup controller slice.
//   KW / DW / AW / DEPTH : key width, data width, address width, entry count
//   CAM_LAT_DEF          : default CAM search latency in cycles
//   ST_*                 : controller FSM state encoding
//   rsp_flags_t          : response flag bundle (hit / learned / full)
// -----------------------------------------------------------------------------
package cam_pkg;

    localparam int KW          = 16;
    localparam int DW          = 16;
    localparam int AW          = 4;
    localparam int DEPTH       = 16;
    localparam int CAM_LAT_DEF = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef struct packed {
        logic hit;
        logic learned;
        logic full;
    } rsp_flags_t;

    localparam rsp_flags_t RSP_FLAGS_NONE = '{hit: 1'b0, learned: 1'b0, full: 1'b0};

endpackage

// File: rtl/cam_lat_timer.sv
// -----------------------------------------------------------------------------
// cam_lat_timer
// Down-counter that paces the CAM search. Loaded with CAM_LAT when a request
// is accepted, counts down while 'run' is high, and raises 'expire' in the
// cycle where the count has reached zero (CAM outputs are then valid).
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load CAM_LAT into the counter
//   run        : count down (controller is in SEARCH)
//   expire     : combinational, run && count == 0
// -----------------------------------------------------------------------------
module cam_lat_timer #(
    parameter int CAM_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = (CAM_LAT < 2) ? 1 : $clog2(CAM_LAT + 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(CAM_LAT);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/cam_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// cam_lookup_ctrl
// Initiator-side controller for a 16-entry CAM. Accepts a lookup on a
// valid/ready request port, drives the CAM search, optionally learns the key
// on a miss (sequential slot fill), and returns the result on a valid/ready
// response port.
//   Request  : req_valid/req_ready, req_key, req_data, req_learn
//   Response : rsp_valid/rsp_ready, rsp_hit, rsp_learned, rsp_full,
//              rsp_addr, rsp_data
//   CAM side : cam_enable, wr, cam_data_in, data_in (out);
//              cam_hit_out, cam_addr_out, data_out (in)
//   Status   : entry_count (entries written, 0..DEPTH)
// -----------------------------------------------------------------------------
module cam_lookup_ctrl
    import cam_pkg::*;
#(
    parameter int KW      = cam_pkg::KW,
    parameter int DW      = cam_pkg::DW,
    parameter int AW      = cam_pkg::AW,
    parameter int DEPTH   = cam_pkg::DEPTH,
    parameter int CAM_LAT = cam_pkg::CAM_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [KW-1:0] req_key,
    input  logic [DW-1:0] req_data,
    input  logic          req_learn,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_hit,
    output logic          rsp_learned,
    output logic          rsp_full,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          cam_enable,
    output logic          wr,
    output logic [KW-1:0] cam_data_in,
    output logic [DW-1:0] data_in,
    input  logic          cam_hit_out,
    input  logic [AW-1:0] cam_addr_out,
    input  logic [DW-1:0] data_out,
    output logic [AW:0]   entry_count
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [1:0]    state;
    logic          init_q;     // low until the first edge after reset release
    logic [KW-1:0] key_q;
    logic [DW-1:0] data_q;
    logic          learn_q;
    rsp_flags_t    rsp_flags;
    logic          accept;
    logic          lat_expire;
    logic          cam_full;

    assign req_ready   = (state == ST_IDLE) && init_q;
    assign accept      = req_ready && req_valid;
    assign cam_full    = (entry_count == FULL_COUNT);

    // The CAM pins come straight from the registered request copies, so they
    // hold their last value once the controller leaves SEARCH/WRITE.
    assign cam_enable  = (state == ST_SEARCH) || (state == ST_WRITE);
    assign wr          = (state == ST_WRITE);
    assign cam_data_in = key_q;
    assign data_in     = data_q;

    assign rsp_hit     = rsp_flags.hit;
    assign rsp_learned = rsp_flags.learned;
    assign rsp_full    = rsp_flags.full;

    cam_lat_timer #(
        .CAM_LAT (CAM_LAT)
    ) u_lat_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .run    (state == ST_SEARCH),
        .expire (lat_expire)
    );

    // NOTE: every register here, including the response and key holding
    // registers, is in the async reset so all outputs read 0 while rst_n is low
    // and wr (decoded from state) drops the moment reset asserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            init_q      <= 1'b0;
            key_q       <= '0;
            data_q      <= '0;
            learn_q     <= 1'b0;
            entry_count <= '0;
            rsp_valid   <= 1'b0;
            rsp_flags   <= RSP_FLAGS_NONE;
            rsp_addr    <= '0;
            rsp_data    <= '0;
        end else begin
            init_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        key_q   <= req_key;
                        data_q  <= req_data;
                        learn_q <= req_learn;
                        state   <= ST_SEARCH;
                    end
                end

                ST_SEARCH: begin
                    if (lat_expire) begin
                        if (cam_hit_out) begin
                            // Existing key wins over learn: no duplicate entries.
                            rsp_flags <= '{hit: 1'b1, learned: 1'b0, full: 1'b0};
                            rsp_addr  <= cam_addr_out;
                            rsp_data  <= data_out;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end else if (learn_q && !cam_full) begin
                            state <= ST_WRITE;
                        end else begin
                            // Plain miss, or learn refused because the CAM is full.
                            rsp_flags <= '{hit: 1'b0, learned: 1'b0, full: learn_q};
                            rsp_addr  <= '0;
                            rsp_data  <= '0;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end

                ST_WRITE: begin
                    // The CAM fills slots in order, so the slot just written is
                    // the pre-increment entry count.
                    entry_count <= entry_count + (AW + 1)'(1);
                    rsp_flags   <= '{hit: 1'b0, learned: 1'b1, full: 1'b0};
                    rsp_addr    <= entry_count[AW-1:0];
                    rsp_data    <= data_q;
                    rsp_valid   <= 1'b1;
                    state       <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_lookup_ctrl
// Directed bench for cam_lookup_ctrl with a behavioural 16-entry CAM
// (sequential slot fill, CAM_LAT-cycle output pipeline) attached.
// -----------------------------------------------------------------------------
module tb_cam_lookup_ctrl;

    localparam int CAM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_key = '0;
    logic [15:0] req_data = '0;
    logic        req_learn = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_hit;
    logic        rsp_learned;
    logic        rsp_full;
    logic [3:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        cam_enable;
    logic        wr;
    logic [15:0] cam_data_in;
    logic [15:0] data_in;
    logic        cam_hit_out;
    logic [3:0]  cam_addr_out;
    logic [15:0] data_out;
    logic [4:0]  entry_count;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    cam_lookup_ctrl #(.CAM_LAT(CAM_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_data     (req_data),
        .req_learn    (req_learn),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_hit      (rsp_hit),
        .rsp_learned  (rsp_learned),
        .rsp_full     (rsp_full),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .cam_enable   (cam_enable),
        .wr           (wr),
        .cam_data_in  (cam_data_in),
        .data_in      (data_in),
        .cam_hit_out  (cam_hit_out),
        .cam_addr_out (cam_addr_out),
        .data_out     (data_out),
        .entry_count  (entry_count)
    );

    always #5 clk = ~clk;

    // Count cycles with the write strobe high, sampled mid-cycle.
    always @(negedge clk) if (wr === 1'b1) wr_cnt++;

    // ---------------- behavioural CAM ----------------
    logic [15:0] m_key [16];
    logic [15:0] m_val [16];
    int          m_used;
    logic        m_hit;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    logic        s1_hit, s2_hit;
    logic [3:0]  s1_addr, s2_addr;
    logic [15:0] s1_data, s2_data;

    always_comb begin
        m_hit  = 1'b0;
        m_addr = '0;
        m_data = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < m_used && !m_hit && m_key[i] == cam_data_in) begin
                m_hit  = 1'b1;
                m_addr = 4'(i);
                m_data = m_val[i];
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_used  <= 0;
            s1_hit  <= 1'b0; s1_addr <= '0; s1_data <= '0;
            s2_hit  <= 1'b0; s2_addr <= '0; s2_data <= '0;
        end else begin
            if (wr && m_used < 16) begin
                m_key[m_used[3:0]] <= cam_data_in;
                m_val[m_used[3:0]] <= data_in;
                m_used <= m_used + 1;
            end
            s1_hit  <= cam_enable && m_hit;
            s1_addr <= cam_enable ? m_addr : 4'h0;
            s1_data <= cam_enable ? m_data : 16'h0;
            s2_hit  <= s1_hit;
            s2_addr <= s1_addr;
            s2_data <= s1_data;
        end
    end

    assign cam_hit_out  = s2_hit;
    assign cam_addr_out = s2_addr;
    assign data_out     = s2_data;

    // ---------------- helpers (stimulus only) ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request and wait for its response. Returns accept-edge to
    // rsp_valid latency in cycles and the number of wr cycles observed.
    task automatic do_txn(input logic [15:0] k, input logic [15:0] d, input logic l,
                          output int lat, output int wrs);
        int w0;
        int guard;
        guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL txn_accept key=%h req_ready=%b expected 1", k, req_ready);
        end
        req_valid = 1'b1;
        req_key   = k;
        req_data  = d;
        req_learn = l;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        // Scramble request pins; the controller must use its registered copy.
        req_valid = 1'b0;
        req_key   = 16'hFFFF;
        req_data  = 16'hDEAD;
        req_learn = ~l;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        wrs = wr_cnt - w0;
    endtask

    task automatic finish_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, cam_enable, wr, entry_count, cam_data_in, rsp_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b en=%b wr=%b cnt=%0d cdi=%h rd=%h expected all 0",
                     req_ready, rsp_valid, cam_enable, wr, entry_count, cam_data_in, rsp_data);
        end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got %b expected 1", req_ready);
        end
    endtask

    task automatic test_learn_first();
        int lat, wrs;
        do_txn(16'h0251, 16'h00AF, 1'b1, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data} !== {3'b010, 4'd0, 16'h00AF}) begin
            errors++;
            $display("FAIL learn_first_rsp got h=%b l=%b f=%b a=%0d d=%h expected l=1 a=0 d=00af",
                     rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data);
        end
        checks++;
        if (lat !== CAM_LAT + 2 || wrs !== 1) begin
            errors++;
            $display("FAIL learn_first_timing got lat=%0d wr=%0d expected lat=%0d wr=1", lat, wrs, CAM_LAT + 2);
        end
        checks++;
        if (entry_count !== 5'd1) begin
            errors++;
            $display("FAIL learn_first_count got %0d expected 1", entry_count);
        end
        finish_rsp();
    endtask

    task automatic test_learn_more();
        int lat, wrs;
        do_txn(16'h0252, 16'h000F, 1'b1, lat, wrs);
        checks++;
        if ({rsp_learned, rsp_addr, rsp_data} !== {1'b1, 4'd1, 16'h000F} || wrs !== 1) begin
            errors++;
            $display("FAIL learn_second got l=%b a=%0d d=%h wr=%0d expected l=1 a=1 d=000f wr=1",
                     rsp_learned, rsp_addr, rsp_data, wrs);
        end
        finish_rsp();
        do_txn(16'h0069, 16'h0012, 1'b1, lat, wrs);
        checks++;
        if ({rsp_learned, rsp_addr, rsp_data} !== {1'b1, 4'd2, 16'h0012} || entry_count !== 5'd3) begin
            errors++;
            $display("FAIL learn_third got l=%b a=%0d d=%h cnt=%0d expected l=1 a=2 d=0012 cnt=3",
                     rsp_learned, rsp_addr, rsp_data, entry_count);
        end
        finish_rsp();
        do_txn(16'h0252, 16'h7777, 1'b0, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data} !== {3'b100, 4'd1, 16'h000F}) begin
            errors++;
            $display("FAIL lookup_hit got h=%b l=%b f=%b a=%0d d=%h expected h=1 a=1 d=000f",
                     rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data);
        end
        checks++;
        if (lat !== CAM_LAT + 1 || wrs !== 0) begin
            errors++;
            $display("FAIL lookup_hit_timing got lat=%0d wr=%0d expected lat=%0d wr=0", lat, wrs, CAM_LAT + 1);
        end
        finish_rsp();
    endtask

    task automatic test_miss();
        int lat, wrs;
        do_txn(16'h1234, 16'h5555, 1'b0, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data} !== '0 || entry_count !== 5'd3) begin
            errors++;
            $display("FAIL lookup_miss got h=%b l=%b f=%b a=%0d d=%h cnt=%0d expected all 0 cnt=3",
                     rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data, entry_count);
        end
        checks++;
        if (lat !== CAM_LAT + 1 || wrs !== 0) begin
            errors++;
            $display("FAIL lookup_miss_timing got lat=%0d wr=%0d expected lat=%0d wr=0", lat, wrs, CAM_LAT + 1);
        end
        finish_rsp();
        do_txn(16'h0251, 16'h3333, 1'b1, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data} !== {3'b100, 4'd0, 16'h00AF}
            || wrs !== 0 || entry_count !== 5'd3) begin
            errors++;
            $display("FAIL relearn_dup got h=%b l=%b a=%0d d=%h wr=%0d cnt=%0d expected h=1 a=0 d=00af wr=0 cnt=3",
                     rsp_hit, rsp_learned, rsp_addr, rsp_data, wrs, entry_count);
        end
        finish_rsp();
    endtask

    task automatic test_fill();
        int lat, wrs;
        logic [22:0] exp_v;
        // Three entries already present: slots 3..15 take the first 13 keys,
        // the last three learns are refused as full.
        for (int i = 0; i < 16; i++) begin
            do_txn(16'h0100 + 16'(i), 16'h0A00 + 16'(i), 1'b1, lat, wrs);
            exp_v = (i < 13) ? {3'b010, 4'(i + 3), 16'h0A00 + 16'(i)} : {3'b001, 4'd0, 16'h0000};
            checks++;
            if ({rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data} !== exp_v || wrs !== ((i < 13) ? 1 : 0)) begin
                errors++;
                $display("FAIL fill_%0d got rsp=%h wr=%0d expected rsp=%h wr=%0d",
                         i, {rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data}, wrs, exp_v, (i < 13) ? 1 : 0);
            end
            finish_rsp();
        end
        do_txn(16'h0200, 16'h4444, 1'b1, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data} !== {3'b001, 4'd0, 16'h0000}
            || wrs !== 0 || entry_count !== 5'd16 || lat !== CAM_LAT + 1) begin
            errors++;
            $display("FAIL full_learn got f=%b l=%b a=%0d d=%h wr=%0d cnt=%0d lat=%0d expected f=1 wr=0 cnt=16 lat=%0d",
                     rsp_full, rsp_learned, rsp_addr, rsp_data, wrs, entry_count, lat, CAM_LAT + 1);
        end
        finish_rsp();
        do_txn(16'h0105, 16'h0000, 1'b0, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_addr, rsp_data} !== {1'b1, 4'd8, 16'h0A05}) begin
            errors++;
            $display("FAIL full_lookup got h=%b a=%0d d=%h expected h=1 a=8 d=0a05", rsp_hit, rsp_addr, rsp_data);
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int lat, wrs;
        logic [25:0] snap;
        do_txn(16'h0069, 16'h0000, 1'b0, lat, wrs);
        snap = {rsp_valid, req_ready, cam_enable, rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data};
        checks++;
        if (snap !== {3'b100, 3'b100, 4'd2, 16'h0012}) begin
            errors++;
            $display("FAIL bp_first got %h expected %h", snap, {3'b100, 3'b100, 4'd2, 16'h0012});
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready, cam_enable, rsp_hit, rsp_learned, rsp_full, rsp_addr, rsp_data}
                !== {3'b100, 3'b100, 4'd2, 16'h0012}) begin
                errors++;
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b en=%b a=%0d d=%h expected held response",
                         c, rsp_valid, req_ready, cam_enable, rsp_addr, rsp_data);
            end
        end
        finish_rsp();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b expected vld=0 rdy=1", rsp_valid, req_ready);
        end
        // rsp_ready already high before the next response must not disturb it.
        rsp_ready = 1'b1;
        do_txn(16'h0251, 16'h0000, 1'b0, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_addr, rsp_data} !== {1'b1, 4'd0, 16'h00AF} || lat !== CAM_LAT + 1) begin
            errors++;
            $display("FAIL early_ready got h=%b a=%0d d=%h lat=%0d expected h=1 a=0 d=00af lat=%0d",
                     rsp_hit, rsp_addr, rsp_data, lat, CAM_LAT + 1);
        end
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_write();
        int guard;
        int lat, wrs;
        int seen_valid;
        apply_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = 16'h0ABC;
        req_data  = 16'h0BCD;
        req_learn = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (wr !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (wr !== 1'b1) begin
            errors++;
            $display("FAIL rstw_reach_write got wr=%b expected 1", wr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr, cam_enable, rsp_valid, req_ready, entry_count} !== '0) begin
            errors++;
            $display("FAIL rstw_async got wr=%b en=%b vld=%b rdy=%b cnt=%0d expected all 0",
                     wr, cam_enable, rsp_valid, req_ready, entry_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen_valid++;
        end
        checks++;
        if (seen_valid !== 0 || req_ready !== 1'b1 || entry_count !== 5'd0) begin
            errors++;
            $display("FAIL rstw_after got valid_cycles=%0d rdy=%b cnt=%0d expected 0 1 0",
                     seen_valid, req_ready, entry_count);
        end
        do_txn(16'h0ABC, 16'h0BCD, 1'b1, lat, wrs);
        checks++;
        if ({rsp_hit, rsp_learned, rsp_addr, rsp_data} !== {2'b01, 4'd0, 16'h0BCD} || entry_count !== 5'd1) begin
            errors++;
            $display("FAIL rstw_relearn got h=%b l=%b a=%0d d=%h cnt=%0d expected l=1 a=0 d=0bcd cnt=1",
                     rsp_hit, rsp_learned, rsp_addr, rsp_data, entry_count);
        end
        finish_rsp();
    endtask

    initial begin
        test_reset();
        test_learn_first();
        test_learn_more();
        test_miss();
        test_fill();
        test_backpressure();
        test_reset_in_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
